// File: rtl/fire4_squeeze_ofm_writer_pkg.sv
// Shared defaults, state encoding and sizing helpers for the fire4 squeeze
// output feature-map writer.
package fmap_pkg;

  localparam int FMAP_WIDTH  = 16;
  localparam int FMAP_DSP_NO = 32;
  localparam int FMAP_WOUT   = 32;

  // Number of RAM words needed for a WOUT x WOUT map of DSP_NO channels.
  function automatic int fmap_depth(input int wout, input int dsp_no);
    return wout * wout * dsp_no;
  endfunction

  localparam int FMAP_DEPTH  = fmap_depth(FMAP_WOUT, FMAP_DSP_NO);
  localparam int FMAP_ADDR_W = $clog2(FMAP_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WAIT_FIN = 3'd2,
    ST_ACK      = 3'd3,
    ST_READ     = 3'd4,
    ST_DONE     = 3'd5
  } wr_state_t;

endpackage

// File: rtl/fire4_squeeze_ofm_writer_if.sv
// Handshake bundle between the squeeze layer / expand consumer (master side)
// and the feature-map writer (slave side).
interface fire4_squeeze_ofm_writer_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 32
);
  logic             ofm_sample;
  logic [WIDTH-1:0] ofm [0:DSP_NO-1];
  logic             layer_finish;
  logic             ram_feedback;
  logic             rd_en;
  logic [WIDTH-1:0] ifm_out;
  logic             ifm_valid;
  logic             done;
  logic             overrun;

  modport master (
    output ofm_sample, ofm, layer_finish, rd_en,
    input  ram_feedback, ifm_out, ifm_valid, done, overrun
  );

  modport slave (
    input  ofm_sample, ofm, layer_finish, rd_en,
    output ram_feedback, ifm_out, ifm_valid, done, overrun
  );
endinterface

// File: rtl/fire4_squeeze_ofm_writer_ram.sv
// Single-port synchronous feature-map RAM with registered read data.
// No reset so the array maps onto block RAM; the read register only updates
// on a read, so it holds the last word between reads.
module fmap_ram_sp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdata;

  // Write has priority; the controller never asks for both in one cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fire4_squeeze_ofm_writer.sv
// Captures squeeze-layer output vectors, serialises them channel by channel
// into the feature-map RAM, acknowledges layer completion and then replays
// the map as a pixel-major / channel-minor stream.
module fire4_squeeze_ofm_writer
  import fmap_pkg::*;
#(
  parameter int WIDTH  = FMAP_WIDTH,
  parameter int DSP_NO = FMAP_DSP_NO,
  parameter int WOUT   = FMAP_WOUT
) (
  input logic                   clk,
  input logic                   rst,
  fire4_squeeze_ofm_writer_if.slave bus
);

  localparam int NPIX  = WOUT * WOUT;
  localparam int DEPTH = fmap_depth(WOUT, DSP_NO);
  localparam int AW    = $clog2(DEPTH);
  localparam int CH_W  = $clog2(DSP_NO);
  localparam int PIX_W = $clog2(NPIX) + 1;
  localparam int RA_W  = $clog2(DEPTH) + 1;

  wr_state_t        r_state;
  wr_state_t        w_next;

  logic [WIDTH-1:0] r_cap [0:DSP_NO-1];
  logic [CH_W-1:0]  r_ch_cnt;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [RA_W-1:0]  r_rd_addr;

  logic             r_ram_feedback;
  logic             r_ifm_valid;
  logic             r_done;
  logic             r_overrun;
  logic             r_rd_seen;

  logic             w_fb_nxt;
  logic             w_done_nxt;
  logic             w_ovr_nxt;

  logic             w_pix_full;
  logic             w_accept;
  logic             w_last_ch;
  logic             w_pix_last;
  logic             w_rd_last;
  logic             w_wr_en;
  logic             w_rd_fire;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_ram_q;

  assign w_pix_full = (r_pix_cnt == PIX_W'(NPIX));
  // A new vector is only taken while the write engine is free and the map
  // still has room; trailing pulses after the map is full fall out here.
  assign w_accept   = bus.ofm_sample && !w_pix_full &&
                      ((r_state == ST_IDLE) || (r_state == ST_WAIT_FIN));
  assign w_last_ch  = (r_ch_cnt == CH_W'(DSP_NO - 1));
  assign w_pix_last = (r_pix_cnt == PIX_W'(NPIX - 1));
  assign w_rd_last  = (r_rd_addr == RA_W'(DEPTH - 1));
  assign w_wr_en    = (r_state == ST_WRITE);
  assign w_rd_fire  = (r_state == ST_READ) && bus.rd_en;
  assign w_wr_addr  = AW'(r_pix_cnt) * AW'(DSP_NO) + AW'(r_ch_cnt);
  assign w_addr     = w_wr_en ? w_wr_addr : r_rd_addr[AW-1:0];
  assign w_wdata    = r_cap[r_ch_cnt];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; capture beats a simultaneous finish while not full.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_WRITE;
        else          w_next = ST_IDLE;
      end
      ST_WRITE: begin
        if (w_last_ch) w_next = w_pix_last ? ST_WAIT_FIN : ST_IDLE;
        else           w_next = ST_WRITE;
      end
      ST_WAIT_FIN: begin
        if (w_accept)              w_next = ST_WRITE;
        else if (bus.layer_finish) w_next = ST_ACK;
        else                       w_next = ST_WAIT_FIN;
      end
      ST_ACK: begin
        w_next = ST_READ;
      end
      ST_READ: begin
        if (w_rd_fire && w_rd_last) w_next = ST_DONE;
        else                        w_next = ST_READ;
      end
      ST_DONE: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    w_fb_nxt   = 1'b0;
    w_done_nxt = r_done;
    w_ovr_nxt  = r_overrun;
    if ((w_next == ST_ACK) && (r_state != ST_ACK)) w_fb_nxt = 1'b1;
    else                                           w_fb_nxt = 1'b0;
    if (r_state == ST_DONE) w_done_nxt = 1'b1;
    else                    w_done_nxt = r_done;
    if (bus.ofm_sample && (r_state == ST_WRITE)) w_ovr_nxt = 1'b1;
    else                                         w_ovr_nxt = r_overrun;
  end

  // Output registers; the valid strobe trails the RAM read by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ram_feedback <= 1'b0;
      r_ifm_valid    <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
      r_rd_seen      <= 1'b0;
    end else begin
      r_ram_feedback <= w_fb_nxt;
      r_ifm_valid    <= w_rd_fire;
      r_done         <= w_done_nxt;
      r_overrun      <= w_ovr_nxt;
      r_rd_seen      <= r_rd_seen | w_rd_fire;
    end
  end

  // Capture register: snapshot of the whole channel vector on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < DSP_NO; c++) r_cap[c] <= '0;
    end else if (w_accept) begin
      for (int c = 0; c < DSP_NO; c++) r_cap[c] <= bus.ofm[c];
    end
  end

  // Channel and pixel counters that walk the write address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      r_ch_cnt  <= '0;
    end else if (r_state == ST_WRITE) begin
      r_ch_cnt <= w_last_ch ? CH_W'(0) : r_ch_cnt + CH_W'(1);
      if (w_last_ch) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
    end
  end

  // Read address: restarts on acknowledge, advances once per issued read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
    end else if (r_state == ST_ACK) begin
      r_rd_addr <= '0;
    end else if (w_rd_fire) begin
      r_rd_addr <= r_rd_addr + RA_W'(1);
    end
  end

  fmap_ram_sp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_re    (w_rd_fire),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  // The RAM read register has no reset, so the stream reads as zero until
  // the first read after reset and then holds the last word fetched.
  assign bus.ifm_out      = r_rd_seen ? w_ram_q : '0;
  assign bus.ifm_valid    = r_ifm_valid;
  assign bus.ram_feedback = r_ram_feedback;
  assign bus.done         = r_done;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_fire4_squeeze_ofm_writer.sv
// Bench for the fire4 squeeze feature-map writer at reduced size
// (WOUT=2, DSP_NO=4): scenario table plus a reference model of the stored map.
module tb_fire4_squeeze_ofm_writer;

  localparam int WIDTH  = 16;
  localparam int DSP_NO = 4;
  localparam int WOUT   = 2;
  localparam int NPIX   = WOUT * WOUT;
  localparam int DEPTH  = NPIX * DSP_NO;

  localparam int M_PLAIN = 0;
  localparam int M_OVR   = 1;
  localparam int M_EARLY = 2;
  localparam int M_STALL = 3;
  localparam int M_TRAIL = 4;
  localparam int M_RAND  = 5;

  typedef struct {
    int mode;
    bit rand_data;
    bit exp_overrun;
    int exp_fb;
    int abort_at;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fire4_squeeze_ofm_writer_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO)) bus();

  fire4_squeeze_ofm_writer #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .WOUT(WOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] words[$];
  int fb_cnt   = 0;
  bit rd_phase = 1'b0;
  bit prev_rd  = 1'b0;
  bit mon_on   = 1'b0;
  rec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: counts acknowledges, collects streamed words, checks the
  // valid strobe follows the read request by one cycle.
  always @(negedge clk) begin
    if (mon_on && rst) begin
      if (bus.ram_feedback) fb_cnt++;
      if (rd_phase && words.size() < DEPTH) chk("valid_follows_rd_en", bus.ifm_valid, prev_rd);
      if (bus.ifm_valid) begin
        if (words.size() < DEPTH - 1) chk("done_before_last", bus.done, 0);
        words.push_back(bus.ifm_out);
      end
      prev_rd = rd_phase ? bus.rd_en : 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_feedback"}, bus.ram_feedback, 0);
    chk({tag, "_ifm_valid"},    bus.ifm_valid,    0);
    chk({tag, "_done"},         bus.done,         0);
    chk({tag, "_overrun"},      bus.overrun,      0);
    chk({tag, "_ifm_out"},      bus.ifm_out,      0);
  endtask

  task automatic do_reset();
    mon_on   = 1'b0;
    rd_phase = 1'b0;
    rst = 1'b0;
    bus.ofm_sample   = 1'b0;
    bus.layer_finish = 1'b0;
    bus.rd_en        = 1'b0;
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    words.delete();
    fb_cnt  = 0;
    prev_rd = 1'b0;
    mon_on  = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v [DSP_NO]);
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = v[c];
    bus.ofm_sample = 1'b1;
    tick();
    bus.ofm_sample = 1'b0;
  endtask

  task automatic run_scenario(input rec_t r);
    logic [WIDTH-1:0] pix [NPIX][DSP_NO];
    logic [WIDTH-1:0] junk [DSP_NO];
    logic [WIDTH-1:0] exp_q[$];
    bit got_fb;
    int guard;
    int gap;
    got_fb = 1'b0;
    do_reset();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < DSP_NO; c++)
        pix[p][c] = r.rand_data ? WIDTH'($urandom) : WIDTH'(16 * p + c);
    for (int c = 0; c < DSP_NO; c++) junk[c] = WIDTH'($urandom) | 16'h8000;
    // Reference: every accepted pixel stored in arrival order, channels inner.
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < DSP_NO; c++) exp_q.push_back(pix[p][c]);

    for (int p = 0; p < NPIX; p++) begin
      if (r.mode == M_EARLY && p == 2) bus.layer_finish = 1'b1;
      if (r.mode == M_EARLY && p == 3) chk("early_fin_no_ack_yet", fb_cnt, 0);
      send(pix[p]);
      if (r.mode == M_OVR && p == 0) begin
        tick();
        send(junk);
      end
      if (r.mode == M_EARLY && p == 3) begin
        // Writes land on edges N+1..N+4, WAIT_FIN from N+4, ack during N+5.
        for (int k = 1; k <= 6; k++) begin
          tick();
          chk($sformatf("early_fin_ack_cycle%0d", k), bus.ram_feedback, (k == 5) ? 1 : 0);
        end
        got_fb = 1'b1;
      end else begin
        gap = (r.mode == M_RAND) ? $urandom_range(4, 10) : 39;
        repeat (gap) tick();
      end
    end
    if (r.mode == M_TRAIL) begin
      send(junk);
      repeat (10) tick();
    end
    chk("overrun_after_fill", bus.overrun, r.exp_overrun);

    if (!got_fb) begin
      chk("no_ack_before_finish", fb_cnt, 0);
      bus.layer_finish = 1'b1;
      guard = 0;
      while (!bus.ram_feedback && guard < 200) begin
        tick();
        guard++;
      end
      chk("ack_latency", guard, 1);
      tick();
    end

    rd_phase = 1'b1;
    guard = 0;
    while (guard < 400 && !(words.size() >= DEPTH && bus.done)) begin
      if (r.abort_at >= 0 && words.size() == r.abort_at) begin
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        mon_on = 1'b0;
        rd_phase = 1'b0;
        return;
      end
      case (r.mode)
        M_STALL: bus.rd_en = (guard % 2 == 0);
        M_RAND:  bus.rd_en = 1'($urandom_range(0, 1));
        default: bus.rd_en = 1'b1;
      endcase
      tick();
      guard++;
    end

    chk("stream_length", words.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < words.size()) chk($sformatf("word%0d", i), words[i], exp_q[i]);
    chk("done_final", bus.done, 1);
    chk("ack_count", fb_cnt, r.exp_fb);
    chk("overrun_final", bus.overrun, r.exp_overrun);
    bus.rd_en = 1'b1;
    repeat (3) begin
      tick();
      chk("done_ignores_rd_en", bus.ifm_valid, 0);
    end
    bus.rd_en = 1'b0;
    rd_phase = 1'b0;
    bus.layer_finish = 1'b0;
  endtask

  initial begin
    tbl[0] = '{M_PLAIN, 1'b0, 1'b0, 1, -1};
    tbl[1] = '{M_OVR,   1'b0, 1'b1, 1, -1};
    tbl[2] = '{M_EARLY, 1'b1, 1'b0, 1, -1};
    tbl[3] = '{M_STALL, 1'b1, 1'b0, 1, -1};
    tbl[4] = '{M_PLAIN, 1'b0, 1'b0, 1, 7};
    tbl[5] = '{M_RAND,  1'b1, 1'b0, 1, -1};
    tbl[6] = '{M_TRAIL, 1'b0, 1'b0, 1, -1};
    tbl[7] = '{M_RAND,  1'b1, 1'b0, 1, -1};
    tbl[8] = '{M_STALL, 1'b0, 1'b0, 1, -1};
    tbl[9] = '{M_RAND,  1'b1, 1'b0, 1, -1};

    rst = 1'b0;
    bus.ofm_sample   = 1'b0;
    bus.layer_finish = 1'b0;
    bus.rd_en        = 1'b0;
    for (int c = 0; c < DSP_NO; c++) bus.ofm[c] = '0;

    for (int t = 0; t < 10; t++) run_scenario(tbl[t]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
